// File: rtl/window_shift_reg.sv
// Sliding window of the last DEPTH accepted samples with valid/ready input, fill tracking and strided strobe.
// Optional output register stage on taps/win_valid: define WINDOW_SHIFT_REG_OUTREG_EN.

module window_shift_reg_tap #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (clear)   q_d = '0;
      else if (en) q_d = d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) q_q <= '0;
      else     q_q <= q_d;
   end

   assign q = q_q;
endmodule

module window_shift_reg #(
   parameter  int WIDTH  = 16,
   parameter  int DEPTH  = 4,
   parameter  int STRIDE = 1,
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [WIDTH-1:0]       in_data,
   output logic                   in_ready,
   input  logic                   pause,
   input  logic                   clear,
   output logic [WIDTH*DEPTH-1:0] taps,
   output logic [CNT_W-1:0]       fill,
   output logic                   full,
   output logic                   win_valid
);
   logic                               accept;
   logic [DEPTH-1:0][WIDTH-1:0]        win;
   logic [DEPTH-1:0][WIDTH-1:0]        win_nxt;
   logic [CNT_W-1:0]                   fill_q, fill_d;
   logic [CNT_W-1:0]                   stride_q, stride_d;
   logic                               wv_q, wv_d;

   assign in_ready = !pause && !clear && !rst;
   assign accept   = in_valid && in_ready;
   assign full     = (fill_q == CNT_W'(DEPTH));
   assign fill     = fill_q;

   // Newest sample enters tap0; every tap takes its younger neighbour.
   assign win_nxt = {win[DEPTH-2:0], in_data};

   for (genvar k = 0; k < DEPTH; k++) begin : g_tap
      window_shift_reg_tap #(.WIDTH(WIDTH)) u_tap (
         .clk   (clk),
         .rst   (rst),
         .clear (clear),
         .en    (accept),
         .d     (win_nxt[k]),
         .q     (win[k])
      );
   end

   always_comb begin
      fill_d   = fill_q;
      stride_d = stride_q;
      wv_d     = 1'b0;
      if (clear) begin
         fill_d   = '0;
         stride_d = '0;
      end else if (accept) begin
         if (!full) fill_d = fill_q + CNT_W'(1);
         // The shift that completes the window always strobes and restarts the stride phase.
         if (fill_q == CNT_W'(DEPTH - 1)) begin
            wv_d     = 1'b1;
            stride_d = '0;
         end else if (full && stride_q == CNT_W'(STRIDE - 1)) begin
            wv_d     = 1'b1;
            stride_d = '0;
         end else if (full) begin
            stride_d = stride_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fill_q   <= '0;
         stride_q <= '0;
         wv_q     <= 1'b0;
      end else begin
         fill_q   <= fill_d;
         stride_q <= stride_d;
         wv_q     <= wv_d;
      end
   end

`ifdef WINDOW_SHIFT_REG_OUTREG_EN
   // Output stage captures the window the cycle after it was updated by an accept.
   logic                        acc_q, acc_d;
   logic [DEPTH-1:0][WIDTH-1:0] otaps_q, otaps_d;
   logic                        owv_q, owv_d;

   always_comb begin
      acc_d   = accept;
      otaps_d = otaps_q;
      owv_d   = 1'b0;
      if (clear) begin
         acc_d   = 1'b0;
         otaps_d = '0;
      end else if (acc_q) begin
         otaps_d = win;
         owv_d   = wv_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q   <= 1'b0;
         otaps_q <= '0;
         owv_q   <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         otaps_q <= otaps_d;
         owv_q   <= owv_d;
      end
   end

   assign taps      = otaps_q;
   assign win_valid = owv_q;
`else
   assign taps      = win;
   assign win_valid = wv_q;
`endif
endmodule

// File: doc/window_shift_reg.md
Name: window_shift_reg

Overview:
- Parametrised successor of the fixed 4-tap shift register in the CNN datapath.
- Holds the last DEPTH accepted samples as a sliding window that feeds the convolution MAC array.
- Adds a valid/ready input handshake, fill tracking, a strided window-valid strobe and a synchronous clear for row/frame boundaries.
- Sits between the line-buffer read port and the PE array.

Parameters:
WIDTH, 16, bit width of one sample
DEPTH, 4, number of taps (window length); legal range 2..32
STRIDE, 1, accepted shifts between successive win_valid strobes once full; legal range 1..DEPTH
CNT_W, $clog2(DEPTH+1), localparam, width of fill counter (derived, not overridable)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  in_data carries a sample
in_data  input  WIDTH  sample to shift in
in_ready  output  1  block can accept a sample this cycle
pause  input  1  stall; holds all state, deasserts in_ready
clear  input  1  synchronous flush of window, fill and stride state
taps  output  WIDTH*DEPTH  window; tap k at bits [k*WIDTH +: WIDTH], tap0 = newest
fill  output  CNT_W  number of valid taps, saturates at DEPTH
full  output  1  fill == DEPTH
win_valid  output  1  one-cycle strobe: taps holds a window due for processing

Behaviour:
- Async reset (rst=1): taps=0, fill=0, stride_cnt=0, win_valid=0. full=0 and in_ready=0 while rst is high.
- in_ready = !pause && !clear && !rst (combinational).
- Accepted shift: accept = in_valid && in_ready.
- On an accepted-shift edge: tap0<=in_data and tap k<=tap k-1 for k=1..DEPTH-1. The oldest tap is discarded.
- Latency: a sample is visible at tap0 the cycle after acceptance. It reaches tap k k accepted shifts later.
- No accept (in_valid=0, or pause=1): all state holds and win_valid=0 next cycle.
- pause with in_valid=1: the sample is not consumed. Upstream must hold in_valid/in_data until in_ready=1 (standard valid/ready rule).
- fill: increments by 1 per accept while fill<DEPTH, then holds at DEPTH. full is decoded from the fill register.
- Stride control, on each accept:
  - If fill==DEPTH-1 (this shift completes the window): win_valid<=1, stride_cnt<=0.
  - Else if full and stride_cnt==STRIDE-1: win_valid<=1, stride_cnt<=0.
  - Else if full: stride_cnt<=stride_cnt+1, win_valid<=0.
  - Else: win_valid<=0.
- win_valid is registered and coincides with the updated taps. It is never high for two cycles unless two consecutive accepts both qualify (STRIDE=1 streaming).
- STRIDE=1: win_valid is high after every accept once full.
- clear=1 (synchronous): next edge sets taps=0, fill=0, stride_cnt=0, win_valid=0.
- clear has priority over everything. in_ready=0, so no sample is consumed in the clear cycle.
- clear and pause together: clear wins.
- rst mid-stream: state clears immediately, independent of clk. First accept after rst deasserts behaves as from empty.
- No internal arithmetic on samples; data passes through bit-exact.

Optional Feature:
- Macro WINDOW_SHIFT_REG_OUTREG_EN.
- Defined: taps and win_valid pass through one extra register stage, reset to 0 by rst and cleared by clear. Latency from accept to tap0/win_valid becomes 2 cycles. The output register loads only on accept or clear. fill, full and in_ready are unaffected (not delayed).
- Undefined: taps and win_valid come directly from the window registers, latency 1 cycle.

Test Plan:
- Reset/fill (WIDTH=16, DEPTH=4, STRIDE=1): after rst, accept 0x0001..0x0004 on consecutive cycles -> fill 1,2,3,4. win_valid=1 only after 4th accept, with taps = {0x0001,0x0002,0x0003,0x0004} (tap3..tap0). full=1.
- Stride (STRIDE=2): stream 0x0001..0x0008 -> win_valid after accepts 4, 6, 8. Tap0 = 0x0004, 0x0006, 0x0008 at those strobes.
- Pause: full window, in_valid=1, in_data=0x00AA, pause=1 for 3 cycles -> in_ready=0, taps/fill unchanged, win_valid=0. On release, 0x00AA is at tap0 the next cycle.
- Clear priority: clear=1 with in_valid=1, in_data=0x1234 -> next cycle taps all 0, fill=0, win_valid=0, 0x1234 not stored.
- Async reset mid-stream: rst pulse between clock edges while fill=3 -> taps=0, fill=0 immediately. Subsequent 4 accepts reproduce the first scenario.
- OUTREG build (macro defined): repeat the first scenario -> win_valid and final taps appear one cycle later. fill still reaches 4 on the original cycle.
